// File: rtl/bitbakery_serial_pkg.sv
// rtl/bitbakery_serial_pkg.sv - shared constants and receiver state encoding for the bitbakery serial link
package bitbakery_serial_pkg;

  localparam int TICKS_PER_BIT_DEFAULT = 434;
  localparam int FRAME_BITS            = 11;
  localparam int PACKET_BYTES          = 4;
  localparam int DATA_BITS             = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction

endpackage

// File: rtl/bitbakery_serial_rx_if.sv
// rtl/bitbakery_serial_rx_if.sv - serial input and packet/status outputs of the receiver
interface bitbakery_serial_rx_if;

  logic       entrada_serial;
  logic [7:0] D0;
  logic [7:0] D1;
  logic [7:0] D2;
  logic [7:0] D3;
  logic       pronto;
  logic       byte_valido;
  logic [7:0] byte_dado;
  logic       erro_paridade;
  logic       erro_frame;

  modport master (
    output entrada_serial,
    input  D0, D1, D2, D3, pronto, byte_valido, byte_dado, erro_paridade, erro_frame
  );

  modport slave (
    input  entrada_serial,
    output D0, D1, D2, D3, pronto, byte_valido, byte_dado, erro_paridade, erro_frame
  );

endinterface

// File: rtl/bitbakery_serial_rx_byte.sv
// rtl/bitbakery_serial_rx_byte.sv - 8E1 byte receiver: synchroniser, framing FSM and error pulses
module bitbakery_serial_rx_byte
  import bitbakery_serial_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic       rx_line,
  output logic       in_idle,
  output logic       start_entry,
  output logic       wait_exit,
  output logic       byte_ok,
  output logic       byte_err,
  output logic [7:0] byte_data,
  output logic       byte_valido,
  output logic [7:0] byte_dado,
  output logic       erro_paridade,
  output logic       erro_frame
);

  localparam int                TICK_W    = $clog2(TICKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICKS_PER_BIT / 2);

  logic [1:0]        sync_q, sync_d;
  rx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              par_bad_q, par_bad_d;
  logic              byte_valido_q, byte_valido_d;
  logic [7:0]        byte_dado_q, byte_dado_d;
  logic              erro_paridade_q, erro_paridade_d;
  logic              erro_frame_q, erro_frame_d;

  logic rx;
  logic tick_done;

  assign rx        = sync_q[1];
  assign tick_done = (tick_q == TICK_LAST);

  always_comb begin
    sync_d          = {sync_q[0], entrada_serial};
    state_d         = state_q;
    tick_d          = tick_q;
    bit_cnt_d       = bit_cnt_q;
    data_d          = data_q;
    par_bad_d       = par_bad_q;
    byte_valido_d   = 1'b0;
    byte_dado_d     = byte_dado_q;
    erro_paridade_d = 1'b0;
    erro_frame_d    = 1'b0;
    start_entry     = 1'b0;
    wait_exit       = 1'b0;
    byte_ok         = 1'b0;
    byte_err        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The line is only ever high on entry to IDLE, so a low level here is the falling edge.
        if (!rx) begin
          state_d     = ST_START;
          tick_d      = '0;
          start_entry = 1'b1;
        end
      end
      ST_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d    = '0;
          bit_cnt_d = '0;
          state_d   = rx ? ST_IDLE : ST_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick_done) begin
          tick_d    = '0;
          data_d    = {rx, data_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (tick_done) begin
          tick_d    = '0;
          par_bad_d = parity_bad(data_q, rx);
          state_d   = ST_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick_done) begin
          tick_d = '0;
          if (rx) begin
            state_d = ST_IDLE;
            if (!par_bad_q) begin
              byte_ok       = 1'b1;
              byte_valido_d = 1'b1;
              byte_dado_d   = data_q;
            end else begin
              byte_err        = 1'b1;
              erro_paridade_d = 1'b1;
            end
          end else begin
            state_d         = ST_WAIT_HIGH;
            byte_err        = 1'b1;
            erro_frame_d    = 1'b1;
            erro_paridade_d = par_bad_q;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx) begin
          state_d   = ST_IDLE;
          wait_exit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q          <= 2'b11;
      state_q         <= ST_IDLE;
      tick_q          <= '0;
      bit_cnt_q       <= '0;
      data_q          <= '0;
      par_bad_q       <= 1'b0;
      byte_valido_q   <= 1'b0;
      byte_dado_q     <= '0;
      erro_paridade_q <= 1'b0;
      erro_frame_q    <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      tick_q          <= tick_d;
      bit_cnt_q       <= bit_cnt_d;
      data_q          <= data_d;
      par_bad_q       <= par_bad_d;
      byte_valido_q   <= byte_valido_d;
      byte_dado_q     <= byte_dado_d;
      erro_paridade_q <= erro_paridade_d;
      erro_frame_q    <= erro_frame_d;
    end
  end

  assign rx_line       = rx;
  assign in_idle       = (state_q == ST_IDLE);
  assign byte_data     = data_q;
  assign byte_valido   = byte_valido_q;
  assign byte_dado     = byte_dado_q;
  assign erro_paridade = erro_paridade_q;
  assign erro_frame    = erro_frame_q;

endmodule

// File: rtl/bitbakery_serial_rx.sv
// rtl/bitbakery_serial_rx.sv - reassembles 4-byte packets from the 8E1 byte receiver into D0..D3
module bitbakery_serial_rx
  import bitbakery_serial_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEFAULT,
  parameter int IDLE_BITS     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  bitbakery_serial_rx_if.slave bus
);

  localparam int                IDLE_MAX_I = IDLE_BITS * TICKS_PER_BIT;
  localparam int                IDLE_W     = $clog2(IDLE_MAX_I + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_MAX_I);
  localparam int                IDX_W      = $clog2(PACKET_BYTES);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(PACKET_BYTES - 1);

  logic              rx_line;
  logic              in_idle;
  logic              start_entry;
  logic              wait_exit;
  logic              byte_ok;
  logic              byte_err;
  logic [7:0]        byte_data;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]        shadow_q [PACKET_BYTES];
  logic [7:0]        shadow_d [PACKET_BYTES];
  logic [7:0]        d_q [PACKET_BYTES];
  logic [7:0]        d_d [PACKET_BYTES];
  logic              pronto_q, pronto_d;

  bitbakery_serial_rx_byte #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_byte (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(bus.entrada_serial),
    .rx_line       (rx_line),
    .in_idle       (in_idle),
    .start_entry   (start_entry),
    .wait_exit     (wait_exit),
    .byte_ok       (byte_ok),
    .byte_err      (byte_err),
    .byte_data     (byte_data),
    .byte_valido   (bus.byte_valido),
    .byte_dado     (bus.byte_dado),
    .erro_paridade (bus.erro_paridade),
    .erro_frame    (bus.erro_frame)
  );

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    d_d        = d_q;
    pronto_d   = 1'b0;

    if (start_entry || wait_exit) begin
      idle_cnt_d = '0;
    end else if (in_idle && rx_line && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    // A long quiet line means the sender restarted; drop any half-built packet silently.
    if (byte_ok) begin
      shadow_d[idx_q] = byte_data;
      if (idx_q == IDX_LAST) begin
        d_d      = shadow_d;
        pronto_d = 1'b1;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (byte_err) begin
      idx_d = '0;
    end else if ((idle_cnt_q == IDLE_MAX) && (idx_q != '0)) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      idle_cnt_q <= '0;
      pronto_q   <= 1'b0;
      for (int i = 0; i < PACKET_BYTES; i++) begin
        shadow_q[i] <= '0;
        d_q[i]      <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      idle_cnt_q <= idle_cnt_d;
      pronto_q   <= pronto_d;
      shadow_q   <= shadow_d;
      d_q        <= d_d;
    end
  end

  assign bus.D0     = d_q[0];
  assign bus.D1     = d_q[1];
  assign bus.D2     = d_q[2];
  assign bus.D3     = d_q[3];
  assign bus.pronto = pronto_q;

endmodule

// File: doc/bitbakery_serial_rx.md
Name: bitbakery_serial_rx

Overview:
- Receives the 8E1 UART stream produced by bitbakery_serial_tx: 1 start, 8 data LSB-first, even parity, 1 stop.
- Reassembles each 4-byte packet into D0..D3.
- Presents the packet atomically with a one-cycle strobe.
- Sits at the receiving FPGA's serial input and feeds the game logic with the four bytes.

Parameters:
- TICKS_PER_BIT, 434: clock cycles per bit (50 MHz / 115200).
- IDLE_BITS, 3: line-high bit-times that resynchronise the packet byte index to 0.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- entrada_serial  in  1  asynchronous serial line; idles high.
- D0  out  8  packet byte 0 (first byte received).
- D1  out  8  packet byte 1.
- D2  out  8  packet byte 2.
- D3  out  8  packet byte 3.
- pronto  out  1  one-cycle pulse; D0..D3 updated in the same cycle.
- byte_valido  out  1  one-cycle pulse per good byte.
- byte_dado  out  8  last good byte; valid when byte_valido is high.
- erro_paridade  out  1  one-cycle pulse on parity mismatch.
- erro_frame  out  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset values:
  - D0..D3 = 8'h00, byte_dado = 8'h00.
  - All pulses 0.
  - Synchroniser flops = 1.
  - FSM = IDLE, byte index = 0, tick and idle counters = 0.
- Input synchroniser: 2 flops; all logic uses the synchronised value (2-cycle input latency).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE:
    - Falling edge of the synced line -> START, tick counter cleared.
    - While the line is high, the idle counter increments, saturating at IDLE_BITS*TICKS_PER_BIT.
    - On reaching that value with byte index != 0: index reset to 0 and partial shadow discarded, no pulse.
  - START:
    - At tick TICKS_PER_BIT/2 (217), the line is re-sampled.
    - Low -> DATA, tick counter cleared.
    - High -> glitch, back to IDLE, no error pulse.
  - DATA:
    - Sample every TICKS_PER_BIT ticks from start-bit centre.
    - Shift right; first sample lands in bit 0.
    - After 8 samples -> PARITY.
  - PARITY:
    - Sample one bit; ok iff XOR(data[7:0], parity_bit) == 0.
    - Then -> STOP.
  - STOP, sampled at stop-bit centre:
    - Stop = 1 and parity ok:
      - byte_valido pulse; byte_dado <= data.
      - shadow[index] <= data.
      - If index == 3: D0..D3 <= shadow including this byte, pronto pulse, index <= 0. Otherwise index++.
      - -> IDLE.
    - Stop = 1, parity bad:
      - erro_paridade pulse, index <= 0 (packet dropped).
      - -> IDLE.
    - Stop = 0:
      - erro_frame pulse (plus erro_paridade if parity also bad), index <= 0.
      - -> WAIT_HIGH.
  - WAIT_HIGH: stay until the synced line is 1, then -> IDLE, idle counter cleared.
- Latency: pronto and byte_valido assert the cycle after the stop-bit centre sample.
- Shadow and outputs:
  - D0..D3 never change except together with pronto.
  - Partial or erroneous packets never reach D0..D3.
- Idle counter is cleared on every START entry.
- Back-to-back frames (stop followed immediately by start) must be accepted.
  - The next falling edge is detected in IDLE on the cycle after the STOP sample.
- Reset mid-frame: immediate abort to reset values; the next frame is received normally.
- Counters:
  - Tick counter width = clog2(TICKS_PER_BIT).
  - Idle counter width = clog2(IDLE_BITS*TICKS_PER_BIT+1).
  - No wrap: the idle counter saturates.

Decomposition:
- Package bitbakery_serial_pkg, shared with the transmitter:
  - Default TICKS_PER_BIT.
  - FRAME_BITS = 11.
  - PACKET_BYTES = 4.
  - FSM state encoding.
- Sub-module bitbakery_serial_rx_byte:
  - Contains the synchroniser, start/data/parity/stop FSM and error pulses.
  - Outputs byte_valido, byte_dado, erro_paridade, erro_frame.
- Top level holds the byte index, idle counter, shadow and D0..D3.

Test Plan:
- Four packets 41,42,43,44 at 434 ticks/bit, 3-bit-time gap between packets:
  - 4 pronto pulses, 16 byte_valido pulses.
  - D0=41, D1=42, D2=43, D3=44 after each pronto.
- Packet with byte 2 = 43 but parity bit inverted:
  - erro_paridade pulse at that stop centre, no pronto, D0..D3 unchanged.
  - Following clean packet 11,22,33,44 -> pronto, D0..D3 = 11,22,33,44.
- Byte 41 with stop bit forced 0, line held low 2 bit-times, then released:
  - erro_frame pulse; FSM in WAIT_HIGH until release.
  - Next packet is received correctly.
- 100-cycle low glitch on an idle line: no byte_valido, no error pulse, FSM returns to IDLE.
- Two bytes AA,BB, then 3 bit-times idle, then 01,02,03,04:
  - Partial packet discarded.
  - pronto with D0..D3 = 01,02,03,04.
- Reset asserted mid-DATA of byte 3:
  - All outputs return to 0.
  - Next full packet 41..44 yields pronto with correct values.
